// File: rtl/int_alu_pkg.sv
// int_alu_pkg: shared types and defaults for the int_alu operand issue path.
//   DEF_DATA_WIDTH / DEF_TAG_WIDTH : default operand and tag widths
//   issue_state_t                  : issue FSM states (IDLE, SETTLE, HOLD)
//   req_t                          : queued multiply request {plier, cand, tag}
package int_alu_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] plier;
        logic [DEF_DATA_WIDTH-1:0] cand;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } req_t;

endpackage

// File: rtl/int_mult_opq.sv
// int_mult_opq: synchronous operand FIFO for int_mult_issue.
//   clk, rst   : clock, synchronous active-high reset (clears pointers/count)
//   push       : write push_data when not full
//   pop        : advance head when not empty; pop_data is the current head
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module int_mult_opq
    import int_alu_pkg::*;
#(
    parameter type         entry_t = req_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/int_mult_issue.sv
// int_mult_issue: operand issue stage in front of the combinational int_mult.
// Buffers tagged requests, holds each operand pair at the multiplier for
// SETTLE_CYCLES cycles, then samples the product and returns it in order.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : request handshake (in_plier, in_cand, in_tag)
//   mult_plier/mult_cand         : registered operands to int_mult
//   mult_result                  : product from int_mult
//   out_valid/out_ready          : result handshake (out_result, out_tag)
//   busy                         : FSM not IDLE or FIFO non-empty
//   count                        : FIFO occupancy
// Optional macro INT_MULT_ISSUE_STATS_EN adds saturating counters:
//   stat_issued : result handshakes
//   stat_stall  : cycles with in_valid && !in_ready
module int_mult_issue
    import int_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_plier,
    input  logic [DATA_WIDTH-1:0]     in_cand,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic [DATA_WIDTH-1:0]     mult_plier,
    output logic [DATA_WIDTH-1:0]     mult_cand,
    input  logic [DATA_WIDTH-1:0]     mult_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count
`ifdef INT_MULT_ISSUE_STATS_EN
   ,output logic [31:0]               stat_issued,
    output logic [31:0]               stat_stall
`endif
);

    localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Same layout as req_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] plier;
        logic [DATA_WIDTH-1:0] cand;
        logic [TAG_WIDTH-1:0]  tag;
    } opq_entry_t;

    issue_state_t          state;
    logic [SCW-1:0]        settle_cnt;
    logic [TAG_WIDTH-1:0]  cur_tag;
    opq_entry_t            push_data;
    opq_entry_t            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    assign push_data = '{plier: in_plier, cand: in_cand, tag: in_tag};
    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // Pop from IDLE, or straight out of HOLD on a handshake so back-to-back
    // requests skip the IDLE bubble.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == HOLD) && out_ready));

    int_mult_opq #(
        .entry_t (opq_entry_t),
        .DEPTH   (DEPTH)
    ) u_opq (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cur_tag    <= '0;
            mult_plier <= '0;
            mult_cand  <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        mult_plier <= head.plier;
                        mult_cand  <= head.cand;
                        cur_tag    <= head.tag;
                        settle_cnt <= SCW'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SCW'(1);
                    end else begin
                        out_result <= mult_result;
                        out_tag    <= cur_tag;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            mult_plier <= head.plier;
                            mult_cand  <= head.cand;
                            cur_tag    <= head.tag;
                            settle_cnt <= SCW'(SETTLE_CYCLES - 1);
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef INT_MULT_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (out_valid && out_ready && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (in_valid && !in_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_int_mult_issue.sv
module tb_int_mult_issue;

    localparam int unsigned DW     = 32;
    localparam int unsigned TW     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_plier;
    logic [DW-1:0]          in_cand;
    logic [TW-1:0]          in_tag;
    logic [DW-1:0]          mult_plier;
    logic [DW-1:0]          mult_cand;
    logic [DW-1:0]          mult_result;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_result;
    logic [TW-1:0]          out_tag;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;
`ifdef INT_MULT_ISSUE_STATS_EN
    logic [31:0]            stat_issued;
    logic [31:0]            stat_stall;
`endif

    // Environment: the combinational multiplier the stage drives.
    assign mult_result = mult_plier * mult_cand;

    always #5 clk = ~clk;

    int_mult_issue #(
        .DATA_WIDTH    (DW),
        .TAG_WIDTH     (TW),
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_plier    (in_plier),
        .in_cand     (in_cand),
        .in_tag      (in_tag),
        .mult_plier  (mult_plier),
        .mult_cand   (mult_cand),
        .mult_result (mult_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .busy        (busy),
        .count       (count)
`ifdef INT_MULT_ISSUE_STATS_EN
       ,.stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    typedef struct {
        logic [DW-1:0] res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   hs_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   mdl_issued = 0;
    int   mdl_stall  = 0;
    int   rdy_mode   = 0;   // 0 hold, 1 toggle, 2 random
    bit   last_acc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Observe the upcoming edge at the negedge, update the reference model,
    // then advance past the posedge.
    task automatic tick();
        logic [DW-1:0] prod;
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            mdl_issued = 0;
            mdl_stall  = 0;
        end else begin
            check("count_le_depth", (count <= DEPTH), 1);
            if (in_valid && !in_ready) mdl_stall++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    check("result", out_result, exp_q[0].res);
                    check("tag", out_tag, exp_q[0].tag);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        mdl_issued++;
                        hs_q.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                prod  = in_plier * in_cand;
                e.res = prod;
                e.tag = in_tag;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_mode == 1) out_ready = ~out_ready;
        else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] p, input logic [DW-1:0] c, input logic [TW-1:0] t);
        int n;
        in_valid = 1'b1;
        in_plier = p;
        in_cand  = c;
        in_tag   = t;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        check("drain", (exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] bp [4];
        logic [DW-1:0] bc [4];
        int k;
        int base;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_plier = '0; in_cand = '0; in_tag = '0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_mult_plier", mult_plier, 0);
        check("rst_mult_cand", mult_cand, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Single op with latency
        send(7, 6, 3);
        for (int i = 1; i <= int'(SETTLE) + 1; i++) begin
            tick();
            check("latency_valid", out_valid, (i == int'(SETTLE) + 1));
        end
        check("single_result", out_result, 42);
        check("single_tag", out_tag, 3);
        drain();
        check("single_busy_idle", busy, 0);

        // Back-to-back
        bp[0] = 2;        bc[0] = 3;
        bp[1] = 5;        bc[1] = 5;
        bp[2] = 'hFFFF;   bc[2] = 'h10000;
        bp[3] = 9;        bc[3] = 9;
        hs_q.delete();
        for (int i = 0; i < 4; i++) send(bp[i], bc[i], 4'(i + 8));
        drain();
        check("b2b_count", hs_q.size(), 4);
        for (int i = 1; i < hs_q.size(); i++)
            check("b2b_interval", hs_q[i] - hs_q[i-1], SETTLE + 1);

        // Full / backpressure (fresh reset so stats start at zero)
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (k < 6);
            in_plier = 32'(k + 11);
            in_cand  = 32'(k * 3 + 1);
            in_tag   = 4'(k);
            tick();
            if (last_acc) k++;
        end
        in_valid = 1'b0;
        check("full_accepted", k, DEPTH + 1);
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        drain();
        check("full_issued", mdl_issued, DEPTH + 1);
`ifdef INT_MULT_ISSUE_STATS_EN
        check("stat_issued", stat_issued, 5);
        check("stat_issued_mdl", stat_issued, 32'(mdl_issued));
        check("stat_stall", stat_stall, 32'(mdl_stall));
`endif

        // Wrap-around with alternating ready
        base = mdl_issued;
        rdy_mode = 1;
        for (int i = 0; i < 3 * int'(DEPTH); i++) send($urandom, $urandom, 4'(i));
        drain();
        rdy_mode = 0;
        out_ready = 1'b1;
        check("wrap_issued", mdl_issued - base, 3 * DEPTH);

        // Mid-op reset with two queued
        out_ready = 1'b0;
        send(100, 3, 1);
        send(200, 3, 2);
        send(300, 3, 3);
        check("pre_rst_count", count, 2);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_mult_plier", mult_plier, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(4, 4, 5);
        for (int i = 0; i <= int'(SETTLE); i++) tick();
        check("midrst_result", out_result, 16);
        check("midrst_tag", out_tag, 5);
        drain();
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            else send($urandom, $urandom, 4'($urandom));
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_mult_issue.md
Name: int_mult_issue

Overview:
Operand issue stage directly upstream of the combinational integer multiplier (int_mult) in the int_alu datapath.
- Accepts tagged multiply requests over a valid/ready interface and buffers them in a small FIFO.
- Drives one operand pair at a time to the multiplier, holding it stable for a configurable settle window.
- Samples the product and returns it with the request tag over a valid/ready result interface. Requests complete strictly in order.

Parameters:
DATA_WIDTH, 32, operand/result width; must match int_mult DATA_WIDTH
TAG_WIDTH, 4, width of request tag carried alongside operands
DEPTH, 4, operand FIFO entries; power of two, >=2
SETTLE_CYCLES, 2, cycles operands are held at the multiplier before the product is sampled; >=1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_plier  in  DATA_WIDTH  multiplier operand
in_cand  in  DATA_WIDTH  multiplicand operand
in_tag  in  TAG_WIDTH  request tag
mult_plier  out  DATA_WIDTH  to int_mult m_plier (registered)
mult_cand  out  DATA_WIDTH  to int_mult m_cand (registered)
mult_result  in  DATA_WIDTH  from int_mult result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_result  out  DATA_WIDTH  sampled product (low DATA_WIDTH bits)
out_tag  out  TAG_WIDTH  tag of the completed request
busy  out  1  high when FSM not IDLE or FIFO non-empty
count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clock and reset are fixed as one clock `clk` and a synchronous, active-high reset `rst`.
  - On rst, clear FIFO pointers and count, return FSM to IDLE, and zero mult_plier, mult_cand, out_result, out_tag and the settle counter.
  - out_valid=0, busy=0, in_ready=1 during and after reset.
  - Reset mid-operation drops the in-flight request and all queued requests; nothing is emitted for them.
- FIFO:
  - in_ready = (count != DEPTH). A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM has three states: IDLE, SETTLE, HOLD.
  - IDLE:
    - If FIFO non-empty, pop head into mult_plier/mult_cand and the tag register, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
    - Otherwise stay in IDLE.
  - SETTLE:
    - If counter != 0, decrement it.
    - If counter == 0, register mult_result into out_result and the tag into out_tag, set out_valid=1, and go to HOLD.
  - HOLD:
    - out_valid stays high and out_result/out_tag stay stable until out_ready.
    - On handshake, if FIFO non-empty (evaluated in the same cycle), pop the next entry into the operand registers, load the counter, and go to SETTLE with out_valid deasserting. This gives back-to-back issue with no IDLE bubble.
    - On handshake with FIFO empty, go to IDLE and deassert out_valid.
- Operands hold their last value while in IDLE and HOLD; mult_* change only on a pop.
- Latency: request accepted at edge E → popped at E+1 (if IDLE) → out_valid high after edge E+1+SETTLE_CYCLES. With defaults, accept at edge 0 gives out_valid from edge 3.
- Throughput: one result per SETTLE_CYCLES+1 cycles when out_ready is held high.
- Arithmetic: no transformation; out_result equals the multiplier output (truncated DATA_WIDTH product) sampled at the end of the settle window.

Optional Feature:
INT_MULT_ISSUE_STATS_EN
- Defined: adds two outputs, both cleared on rst and saturating at all-ones (no wrap).
  - stat_issued (32 bits): counts out_valid && out_ready handshakes.
  - stat_stall (32 bits): counts cycles with in_valid && !in_ready.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package int_alu_pkg holds:
  - default DATA_WIDTH and TAG_WIDTH localparams;
  - state enum typedef (IDLE, SETTLE, HOLD);
  - request struct typedef {plier, cand, tag} used for FIFO storage.
- Sub-module int_mult_opq: parameterised synchronous FIFO with push/pop, full/empty and count. The FSM, settle counter, output registers and stats stay in int_mult_issue.

Test Plan:
- Single op: push plier=7, cand=6, tag=3 with out_ready=1 → out_valid rises 3 edges after accept; out_result=42, out_tag=3; busy returns to 0.
- Back-to-back: push 4 ops (2×3, 5×5, 0xFFFF×0x10000, 9×9) with out_ready=1 → results 6, 25, 0xFFFF0000, 81 in order; one result every 3 cycles; no IDLE between.
- Full/backpressure: out_ready=0, push 6 ops → in_ready drops after 5 accepted (1 in flight + 4 queued), count=4. Raise out_ready → all 5 emitted in order; out_result stays stable while stalled.
- Wrap-around: stream 3×DEPTH ops, alternating out_ready → tags 0..11 emitted in order, count never exceeds DEPTH.
- Mid-op reset: assert rst during SETTLE with 2 queued → next cycle out_valid=0, count=0, mult_plier=0; a subsequent op 4×4 yields 16 with correct tag only.
- STATS_EN: run the full/backpressure scenario → stat_issued=5, stat_stall equals the cycles where in_valid=1 and in_ready=0.
